// File: rtl/riscv_md_unit_param.sv
// RV M-extension unit (MUL*/DIV*/REM*) on a held-valid PCPI handshake; dropping valid before ready aborts.
// Ready at accept+MUL_STAGES+1 (mul), accept+XLEN/DIV_BITS+2 (divide), accept+2 (zero/overflow/fused).
module riscv_md_unit_param #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1,
  parameter int FUSE_EN    = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            wr,
  output logic [XLEN-1:0] rd,
  output logic            busy,
  output logic            ready
);
  localparam int NITER = XLEN / DIV_BITS;
  localparam int CW = $clog2(XLEN + 1) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, FAST, RESP, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_r, b_r, quo, rem, dvs;
  logic [1:0]      f3_r;
  logic            q_neg, r_neg, hit_r;
  logic [XLEN-1:0] mpipe [MUL_STAGES];
  logic            c_vld, c_sgn;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;

  logic            match, in_sgn, in_hit, to_fast;
  logic [2:0]      f3_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            unused_bits;

  assign f3_in   = instruction[14:12];
  assign match   = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
  assign in_sgn  = ~f3_in[0];
  assign in_hit  = (FUSE_EN != 0) && c_vld && (rs1 == c_a) && (rs2 == c_b) && (c_sgn == in_sgn);
  assign to_fast = (rs2 == '0) || (in_sgn && (rs1 == MIN_NEG) && (rs2 == '1)) || in_hit;
  assign a_mag   = (in_sgn && rs1[XLEN-1]) ? -rs1 : rs1;
  assign b_mag   = (in_sgn && rs2[XLEN-1]) ? -rs2 : rs2;
  assign unused_bits = ^{instruction[24:15], instruction[11:7]};

  // Product is formed from the ports in the accept cycle, then rides the mpipe stages.
  logic [2*XLEN-1:0] ea, eb, prod;
  logic [XLEN-1:0]   mres;
  always_comb begin
    ea   = {{XLEN{rs1[XLEN-1] & (f3_in[1:0] != 2'b11)}}, rs1};
    eb   = {{XLEN{rs2[XLEN-1] & ~f3_in[1]}}, rs2};
    prod = ea * eb;
    mres = (f3_in[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Restoring division on magnitudes, DIV_BITS quotient bits per cycle.
  logic [XLEN-1:0] dq, dr;
  logic [XLEN:0]   dt;
  always_comb begin
    dq = quo;
    dr = rem;
    dt = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      dt = {dr, dq[XLEN-1]};
      dq = {dq[XLEN-2:0], 1'b0};
      if (dt >= {1'b0, dvs}) begin
        dt    = dt - {1'b0, dvs};
        dq[0] = 1'b1;
      end
      dr = dt[XLEN-1:0];
    end
  end

  logic [XLEN-1:0] fq, fr, fin;
  logic            fupd;
  always_comb begin
    fupd = 1'b0;
    if (b_r == '0) begin
      fq = '1;
      fr = a_r;
    end else if (!f3_r[0] && (a_r == MIN_NEG) && (b_r == '1)) begin
      fq = a_r;
      fr = '0;
    end else if (hit_r) begin
      fq = c_q;
      fr = c_r;
    end else begin
      fq   = q_neg ? -quo : quo;
      fr   = r_neg ? -rem : rem;
      fupd = 1'b1;
    end
    fin = f3_r[1] ? fr : fq;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
      wr    <= 1'b0;
      rd    <= '0;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      f3_r  <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hit_r <= 1'b0;
      c_vld <= 1'b0;
      c_sgn <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_q   <= '0;
      c_r   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= mres;
      for (int i = 1; i < MUL_STAGES; i++) mpipe[i] <= mpipe[i-1];
      case (state)
        IDLE: if (valid && match) begin
          busy  <= 1'b1;
          a_r   <= rs1;
          b_r   <= rs2;
          f3_r  <= f3_in[1:0];
          quo   <= a_mag;
          rem   <= '0;
          dvs   <= b_mag;
          q_neg <= in_sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
          r_neg <= in_sgn & rs1[XLEN-1];
          hit_r <= in_hit;
          if (!f3_in[2]) begin
            state <= MUL;
            cnt   <= CW'(MUL_STAGES - 1);
          end else if (to_fast) begin
            state <= FAST;
          end else begin
            state <= DIV;
            cnt   <= CW'(NITER - 1);
          end
        end
        MUL: if (!valid) begin
          state <= IDLE;
          busy  <= 1'b0;
          c_vld <= 1'b0;
        end else if (cnt == '0) begin
          state <= RESP;
          ready <= 1'b1;
          wr    <= 1'b1;
          rd    <= mpipe[MUL_STAGES-1];
        end else begin
          cnt <= cnt - CW'(1);
        end
        DIV: if (!valid) begin
          state <= IDLE;
          busy  <= 1'b0;
          c_vld <= 1'b0;
        end else begin
          quo <= dq;
          rem <= dr;
          if (cnt == '0) state <= FAST;
          else cnt <= cnt - CW'(1);
        end
        // Also the sign-fixup cycle for the iterative path, which is what refreshes the cache.
        FAST: if (!valid) begin
          state <= IDLE;
          busy  <= 1'b0;
          c_vld <= 1'b0;
        end else begin
          state <= RESP;
          ready <= 1'b1;
          wr    <= 1'b1;
          rd    <= fin;
          if (fupd && (FUSE_EN != 0)) begin
            c_vld <= 1'b1;
            c_sgn <= ~f3_r[0];
            c_a   <= a_r;
            c_b   <= b_r;
            c_q   <= fq;
            c_r   <= fr;
          end
        end
        RESP: begin
          state <= HOLD;
          busy  <= 1'b0;
          ready <= 1'b0;
          wr    <= 1'b0;
          rd    <= '0;
        end
        HOLD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/riscv_md_unit_param.md
Name: riscv_md_unit_param

Overview:
- Parametrised successor to the fixed 32-bit M-extension coprocessor on the PCPI bus.
- Executes all eight RV M-ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at configurable width.
- Multiplier is pipelined with configurable depth; divider is iterative, radix 2 or radix 4.
- Adds single-cycle fast paths for divide-by-zero and overflow, plus DIV/REM pair fusion.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- MUL_STAGES, 2, register stages in the multiplier; 1..4.
- DIV_BITS, 1, quotient bits retired per divider iteration; 1 or 2; XLEN divisible by DIV_BITS.
- FUSE_EN, 1, 1 enables DIV/REM fusion cache.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  PCPI instruction valid; held by core until ready or trap
- instruction  in  32  instruction word
- rs1  in  XLEN  operand A
- rs2  in  XLEN  operand B
- wr  out  1  result write enable; pulses with ready
- rd  out  XLEN  result; valid only while ready=1, else 0
- busy  out  1  instruction accepted and in progress
- ready  out  1  one-cycle completion strobe

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: wr=0, rd=0, busy=0, ready=0; FSM to IDLE; fusion cache invalid.
- Decode match: opcode=0110011, funct7=0000001; funct3 selects the op.
- Non-matching instruction: never busy, never ready.
- FSM states: IDLE, MUL, DIV, FAST, RESP, HOLD.
- IDLE, valid & match (accept cycle T): latch rs1, rs2 and funct3; busy=1 from T+1.
  - Mul op -> MUL.
  - rs2==0, or signed overflow (rs1 = -2^(XLEN-1), rs2 = -1) -> FAST.
  - Fusion hit -> FAST.
  - Otherwise -> DIV.
- Result latencies, ready=1 and wr=1 for exactly one cycle:
  - Mul ops: ready at T+MUL_STAGES+1.
  - DIV path: XLEN/DIV_BITS iterations; ready at T+XLEN/DIV_BITS+2.
  - FAST path: ready at T+2.
- busy stays high through the ready cycle and drops the cycle after.
- RESP -> HOLD for one cycle; valid is ignored in HOLD so a stale valid is not re-accepted; then IDLE.
- Mul arithmetic:
  - Full 2*XLEN product; MUL returns low half, other mul ops return high half.
  - Extension: MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned.
- Div arithmetic:
  - Magnitudes divided unsigned.
  - Quotient negated when operand signs differ (signed ops).
  - Remainder takes sign of rs1.
- Divide by zero: quotient all-ones; remainder = rs1.
- Signed overflow: quotient = rs1; remainder = 0.
- Fusion (FUSE_EN=1):
  - After any completed DIV path, store {rs1, rs2, signedness, quotient, remainder}; cache becomes valid.
  - Hit: next accepted div-family op has equal rs1, rs2 and signedness; returns the stored companion or same result via FAST.
  - Cache invalidated on reset and abort; a new DIV-path completion overwrites it.
- Abort: valid low while busy and before ready.
  - Next cycle: FSM -> IDLE, busy=0, no ready/wr; partial divider state discarded.
  - In-flight multiplier result suppressed.
- resetn low mid-op: all outputs 0 immediately (async); no result emitted after release.
- valid high with ready in the same cycle: the ready cycle completes normally; valid is not sampled as a new accept until IDLE.

Test Plan (XLEN=32, MUL_STAGES=2, DIV_BITS=1, FUSE_EN=1):
- MUL rs1=7, rs2=0xFFFFFFFD -> rd=0xFFFFFFEB, ready at T+3; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD at T+34; then REM same operands -> 0xFFFFFFFF at T+2 (fused); then REMU same operands -> full T+34 path, 1.
- DIVU 5/0 -> 0xFFFFFFFF at T+2; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0 (all FAST).
- Abort: DIV accepted, valid dropped at T+10 -> busy=0 at T+11, no ready; next REM same operands runs the full DIV path (cache invalid).
- resetn pulsed low at T+5 during DIV -> busy, ready, wr, rd = 0 immediately; no ready pulse after release; next MUL 3x4 -> 12 at T+3.
- Non-M instruction (funct7=0000000) held valid 20 cycles -> busy and ready stay 0; back-to-back MULs with valid held through HOLD -> one result per instruction, no duplicate ready.
